// File: rtl/sreg_in_pkg.sv
// Shared types and constants for the serial-to-parallel capture block.
package sreg_in_pkg;

  typedef enum logic {
    SREG_IN_IDLE  = 1'b0,
    SREG_IN_SHIFT = 1'b1
  } sreg_in_state_e;

  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  // Ceiling log2 for elaboration-time width sizing.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sreg_in_if.sv
// Serial link and CPU-side read port of the capture block.
interface sreg_in_if
  import sreg_in_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             data;
  logic             start;
  logic             rd_en;
  logic             clr_ovf;
  logic [WIDTH-1:0] rd_data;
  logic             isr;
  logic             full;
  logic             busy;
  logic             overflow;

  modport master (
    output data, start, rd_en, clr_ovf,
    input  rd_data, isr, full, busy, overflow
  );

  modport slave (
    input  data, start, rd_en, clr_ovf,
    output rd_data, isr, full, busy, overflow
  );

endinterface

// File: rtl/sreg_in_fifo.sv
// Show-ahead synchronous word FIFO; a pop frees a slot for a push in the same edge.
module sreg_in_fifo
  import sreg_in_pkg::*;
#(
  parameter int unsigned  WIDTH = DEF_WIDTH,
  parameter int unsigned  DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned PTR_W = clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sreg_in.sv
// Serial-to-parallel capture: MSB-first frames assembled into words and queued for the CPU.
module sreg_in
  import sreg_in_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic      clock,
  input  logic      reset,
  sreg_in_if.slave  bus
);

  localparam int unsigned CNT_W  = clog2(WIDTH) + 1;
  localparam int unsigned FCNT_W = clog2(FIFO_DEPTH) + 1;

  sreg_in_state_e    state;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  shreg;
  logic              ovf;

  logic [WIDTH-1:0]  word_c;
  logic              push_c;
  logic              drop_c;
  logic [WIDTH-1:0]  fifo_dout;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_empty;
  logic              fifo_full;

  assign word_c = {shreg[WIDTH-2:0], bus.data};
  assign push_c = (state == SREG_IN_SHIFT) && (cnt == CNT_W'(WIDTH - 1));
  // A full FIFO still takes the word when the CPU pops in the same edge.
  assign drop_c = push_c & fifo_full & ~(bus.rd_en & ~fifo_empty);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= SREG_IN_IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        SREG_IN_IDLE: begin
          if (bus.start) begin
            shreg <= word_c;
            cnt   <= CNT_W'(1);
            state <= SREG_IN_SHIFT;
          end
        end
        SREG_IN_SHIFT: begin
          shreg <= word_c;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            cnt   <= '0;
            state <= SREG_IN_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Sticky drop flag; a new drop beats a simultaneous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)            ovf <= 1'b0;
    else if (drop_c)      ovf <= 1'b1;
    else if (bus.clr_ovf) ovf <= 1'b0;
  end

  sreg_in_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push_c),
    .pop      (bus.rd_en),
    .data_in  (word_c),
    .data_out (fifo_dout),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign bus.rd_data  = fifo_dout;
  assign bus.isr      = (fifo_count != '0);
  assign bus.full     = fifo_full;
  assign bus.busy     = (state == SREG_IN_SHIFT);
  assign bus.overflow = ovf;

endmodule

// File: tb/tb_sreg_in.sv
// Directed bench for sreg_in: frame capture, FIFO queuing, overflow and reset behaviour.
module tb_sreg_in;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  sreg_in_if #(.WIDTH(32)) bus ();

  sreg_in #(
    .WIDTH      (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives one frame starting in the current cycle; returns in the cycle after the last-bit edge.
  task automatic drive_frame(input logic [31:0] w, input bit pop_last, input bit extra_start);
    bus.start = 1'b1;
    bus.data  = w[31];
    for (int i = 30; i >= 0; i--) begin
      @(posedge clock); #1;
      bus.start = (extra_start && i == 21);
      bus.data  = w[i];
      bus.rd_en = (pop_last && i == 0);
    end
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.data  = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clock); #1;
  endtask

  task automatic pop_one();
    bus.rd_en = 1'b1;
    @(posedge clock); #1;
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    total++;
    if ({bus.rd_data, bus.isr, bus.full, bus.busy, bus.overflow} !== 36'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {bus.rd_data, bus.isr, bus.full, bus.busy, bus.overflow});
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    total++;
    if (bus.busy !== 1'b0 || bus.isr !== 1'b0) begin
      bad++;
      $display("FAIL reset_release busy=%b isr=%b exp=0,0", bus.busy, bus.isr);
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] w;
    w = 32'hA5C3_0F96;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL single_busy_pre got=%b exp=0", bus.busy);
    end
    bus.start = 1'b1;
    bus.data  = w[31];
    for (int i = 30; i >= 0; i--) begin
      @(posedge clock); #1;
      total++;
      if (bus.busy !== 1'b1 || bus.isr !== 1'b0) begin
        bad++;
        $display("FAIL single_busy bit=%0d busy=%b isr=%b exp=1,0", 31 - i, bus.busy, bus.isr);
      end
      bus.start = 1'b0;
      bus.data  = w[i];
    end
    @(posedge clock); #1;
    bus.data = 1'b0;
    total++;
    if (bus.isr !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL single_done isr=%b busy=%b exp=1,0", bus.isr, bus.busy);
    end
    total++;
    if (bus.rd_data !== 32'hA5C3_0F96) begin
      bad++;
      $display("FAIL single_data got=%h exp=a5c30f96", bus.rd_data);
    end
    pop_one();
    total++;
    if (bus.isr !== 1'b0) begin
      bad++;
      $display("FAIL single_pop isr=%b exp=0", bus.isr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3];
    w[0] = 32'h0000_0001;
    w[1] = 32'h8000_0000;
    w[2] = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      drive_frame(w[k], 1'b0, 1'b0);
      idle_cycle();
    end
    total++;
    if (bus.overflow !== 1'b0 || bus.full !== 1'b0) begin
      bad++;
      $display("FAIL b2b_flags ovf=%b full=%b exp=0,0", bus.overflow, bus.full);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (bus.isr !== 1'b1 || bus.rd_data !== w[k]) begin
        bad++;
        $display("FAIL b2b_word%0d isr=%b got=%h exp=%h", k, bus.isr, bus.rd_data, w[k]);
      end
      pop_one();
    end
    total++;
    if (bus.isr !== 1'b0) begin
      bad++;
      $display("FAIL b2b_empty isr=%b exp=0", bus.isr);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w [5];
    w[0] = 32'h1111_0001;
    w[1] = 32'h2222_0002;
    w[2] = 32'h3333_0003;
    w[3] = 32'h4444_0004;
    w[4] = 32'h5555_0005;
    for (int k = 0; k < 4; k++) begin
      drive_frame(w[k], 1'b0, 1'b0);
      idle_cycle();
    end
    total++;
    if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_full4 full=%b ovf=%b exp=1,0", bus.full, bus.overflow);
    end
    drive_frame(w[4], 1'b0, 1'b0);
    total++;
    if (bus.overflow !== 1'b1 || bus.full !== 1'b1) begin
      bad++;
      $display("FAIL ovf_drop ovf=%b full=%b exp=1,1", bus.overflow, bus.full);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (bus.rd_data !== w[k]) begin
        bad++;
        $display("FAIL ovf_word%0d got=%h exp=%h", k, bus.rd_data, w[k]);
      end
      pop_one();
    end
    total++;
    if (bus.isr !== 1'b0 || bus.overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_after_reads isr=%b ovf=%b exp=0,1", bus.isr, bus.overflow);
    end
    bus.clr_ovf = 1'b1;
    @(posedge clock); #1;
    bus.clr_ovf = 1'b0;
    total++;
    if (bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear got=%b exp=0", bus.overflow);
    end
  endtask

  task automatic test_full_pop();
    logic [31:0] w [5];
    w[0] = 32'hC0DE_0000;
    w[1] = 32'hC0DE_1111;
    w[2] = 32'hC0DE_2222;
    w[3] = 32'hC0DE_3333;
    w[4] = 32'hC0DE_4444;
    for (int k = 0; k < 4; k++) begin
      drive_frame(w[k], 1'b0, 1'b0);
      idle_cycle();
    end
    drive_frame(w[4], 1'b1, 1'b0);
    total++;
    if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL fpop_flags full=%b ovf=%b exp=1,0", bus.full, bus.overflow);
    end
    for (int k = 1; k < 5; k++) begin
      total++;
      if (bus.rd_data !== w[k]) begin
        bad++;
        $display("FAIL fpop_word%0d got=%h exp=%h", k, bus.rd_data, w[k]);
      end
      pop_one();
    end
    total++;
    if (bus.isr !== 1'b0) begin
      bad++;
      $display("FAIL fpop_empty isr=%b exp=0", bus.isr);
    end
  endtask

  task automatic test_start_ignored();
    drive_frame(32'h0F0F_3C3C, 1'b0, 1'b1);
    total++;
    if (bus.isr !== 1'b1 || bus.rd_data !== 32'h0F0F_3C3C) begin
      bad++;
      $display("FAIL ign_word isr=%b got=%h exp=0f0f3c3c", bus.isr, bus.rd_data);
    end
    pop_one();
    for (int k = 0; k < 40; k++) idle_cycle();
    total++;
    if (bus.isr !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL ign_single isr=%b busy=%b exp=0,0", bus.isr, bus.busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] w;
    w = 32'hDEAD_BEEF;
    drive_frame(32'hAAAA_5555, 1'b0, 1'b0);
    idle_cycle();
    drive_frame(32'h5555_AAAA, 1'b0, 1'b0);
    idle_cycle();
    bus.start = 1'b1;
    bus.data  = w[31];
    for (int k = 1; k <= 16; k++) begin
      @(posedge clock); #1;
      bus.start = 1'b0;
      bus.data  = w[31 - k];
    end
    total++;
    if (bus.busy !== 1'b1 || bus.isr !== 1'b1) begin
      bad++;
      $display("FAIL rmid_pre busy=%b isr=%b exp=1,1", bus.busy, bus.isr);
    end
    #1;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.rd_data, bus.isr, bus.full, bus.busy, bus.overflow} !== 36'd0) begin
      bad++;
      $display("FAIL rmid_async got=%h exp=0", {bus.rd_data, bus.isr, bus.full, bus.busy, bus.overflow});
    end
    @(negedge clock);
    reset    = 1'b0;
    bus.data = 1'b0;
    @(posedge clock); #1;
    drive_frame(32'h1234_5678, 1'b0, 1'b0);
    total++;
    if (bus.isr !== 1'b1 || bus.rd_data !== 32'h1234_5678 || bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL rmid_fresh isr=%b got=%h ovf=%b exp=1,12345678,0", bus.isr, bus.rd_data, bus.overflow);
    end
    pop_one();
    total++;
    if (bus.isr !== 1'b0) begin
      bad++;
      $display("FAIL rmid_empty isr=%b exp=0", bus.isr);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset       = 1'b1;
    bus.data    = 1'b0;
    bus.start   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr_ovf = 1'b0;
    test_reset();
    for (int k = 0; k < 9; k++) idle_cycle();
    test_single_frame();
    idle_cycle();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_start_ignored();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
